// File: rtl/ask_frame_receiver.sv
// ASK slicer and UART-like framer: idle low, high start bit, 8 data bits MSB first, low stop bit.
// Define ASK_RX_STATS_EN to add the frame_cnt/err_cnt statistics outputs.
module ask_frame_receiver #(
  parameter int          SPB       = 16,
  parameter logic [7:0]  THRESHOLD = 8'd128
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  sample,
  input  logic        sample_valid,
  output logic [7:0]  code_word,
  output logic        code_valid,
  output logic        frame_err,
  output logic        busy
`ifdef ASK_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW = $clog2(SPB + 1);
  localparam logic [CW-1:0] LAST = CW'(SPB - 1);
  localparam logic [CW-1:0] HALF = CW'(SPB / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] samp_cnt, samp_n;
  logic [CW-1:0] ones_cnt, ones_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift_reg, shift_n;
  logic [7:0]    word_n;
  logic          valid_n, err_n;
  logic          hi, decide, bit_val;
  logic [CW-1:0] ones_tot;

  assign hi       = (sample >= THRESHOLD);
  assign ones_tot = ones_cnt + {{(CW-1){1'b0}}, hi};
  assign decide   = sample_valid && (state != IDLE) && (samp_cnt == LAST);
  // Strict majority; a tie slices to 0.
  assign bit_val  = (ones_tot > HALF);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    samp_n  = samp_cnt;
    ones_n  = ones_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    word_n  = code_word;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (sample_valid) begin
      if (state == IDLE) begin
        if (hi) begin
          state_n = START;
          samp_n  = CW'(1);
          ones_n  = CW'(1);
        end
      end else if (decide) begin
        samp_n = '0;
        ones_n = '0;
        case (state)
          START: begin
            if (bit_val) begin
              state_n = DATA;
              bit_n   = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end
          DATA: begin
            shift_n = {shift_reg[6:0], bit_val};
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = STOP;
          end
          STOP: begin
            if (bit_val) begin
              err_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              word_n  = shift_reg;
            end
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end else begin
        samp_n = samp_cnt + CW'(1);
        ones_n = ones_tot;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      samp_cnt   <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      code_word  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      samp_cnt   <= samp_n;
      ones_cnt   <= ones_n;
      bit_cnt    <= bit_n;
      shift_reg  <= shift_n;
      code_word  <= word_n;
      code_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

`ifdef ASK_RX_STATS_EN
  // Counters move on the same edge that raises the pulse so they read updated alongside it.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (valid_n) frame_cnt <= frame_cnt + 16'd1;
      if (err_n)   err_cnt   <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
